link_recovery_ctrl: RTL and testbench

- Closed-loop recovery controller that sits beside link_monitor.
- On loss of link it sweeps the ring heater code, scores each code by counting CRC failures over a fixed frame window, then applies the best code.
- After applying, it pulses a monitor clear and checks that the link returns; it retries on timeout and raises a fault once retries are exhausted.
- While the link is up it holds the heater code steady and stays idle.

---
 rtl/link_recovery_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_link_recovery_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/link_recovery_ctrl.sv
// Ring-heater recovery controller: on link loss it sweeps heater codes, scores each by CRC
// failures over a frame window, applies the best code and verifies the link comes back.
module link_recovery_ctrl #(
    parameter int unsigned CODE_W         = 8,
    parameter int unsigned CODE_MIN       = 0,
    parameter int unsigned CODE_MAX       = 255,
    parameter int unsigned CODE_STEP      = 4,
    parameter int unsigned HOLDOFF_CYCLES = 32,
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned OBS_FRAMES     = 16,
    parameter int unsigned VERIFY_CYCLES  = 4096,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              link_up,
    input  logic              valid,
    input  logic              crc_fail,
    input  logic              fault_clear,
    output logic [CODE_W-1:0] heater_code,
    output logic              mon_clear,
    output logic [2:0]        state,
    output logic              busy,
    output logic              fault,
    output logic [CODE_W-1:0] best_code,
    output logic [15:0]       best_fails,
    output logic [1:0]        retry_cnt
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StHoldoff = 3'd1;
    localparam logic [2:0] StSettle  = 3'd2;
    localparam logic [2:0] StObserve = 3'd3;
    localparam logic [2:0] StApply   = 3'd4;
    localparam logic [2:0] StVerify  = 3'd5;
    localparam logic [2:0] StFault   = 3'd6;

    localparam logic [31:0]       HoldoffLast = 32'(HOLDOFF_CYCLES - 1);
    localparam logic [31:0]       SettleLast  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0]       VerifyLast  = 32'(VERIFY_CYCLES - 1);
    localparam logic [15:0]       ObsFrames   = 16'(OBS_FRAMES);
    localparam logic [CODE_W-1:0] CodeMin     = CODE_W'(CODE_MIN);
    localparam logic [CODE_W:0]   CodeMaxW    = (CODE_W + 1)'(CODE_MAX);
    localparam logic [CODE_W:0]   CodeStepW   = (CODE_W + 1)'(CODE_STEP);
    localparam logic [1:0]        MaxRetries  = 2'(MAX_RETRIES);
    localparam logic [15:0]       NoResult    = 16'hFFFF;
    localparam logic [15:0]       FailSat     = 16'hFFFE;

    logic [2:0]        state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [15:0]       frames_q, frames_d;
    logic [15:0]       fails_q, fails_d;
    logic [CODE_W-1:0] heater_q, heater_d;
    logic [CODE_W-1:0] best_code_q, best_code_d;
    logic [15:0]       best_fails_q, best_fails_d;
    logic [1:0]        retry_q, retry_d;
    logic              mon_clear_q, mon_clear_d;

    logic [15:0]       frames_inc;
    logic [15:0]       fails_inc;
    logic [CODE_W:0]   next_code_w;
    logic              sweep_end;

    assign frames_inc  = frames_q + 16'd1;
    // Saturate below the sentinel so a real score never reads as "no result".
    assign fails_inc   = (fails_q == FailSat) ? FailSat : fails_q + {15'd0, crc_fail};
    // One extra bit so the limit check cannot be fooled by code wrap-around.
    assign next_code_w = {1'b0, heater_q} + CodeStepW;
    assign sweep_end   = (next_code_w > CodeMaxW);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frames_d     = frames_q;
        fails_d      = fails_q;
        heater_d     = heater_q;
        best_code_d  = best_code_q;
        best_fails_d = best_fails_q;
        retry_d      = retry_q;

        if (!enable && state_q != StFault) begin
            state_d = StIdle;
            retry_d = 2'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!link_up) begin
                        state_d = StHoldoff;
                        cnt_d   = 32'd0;
                    end
                end
                StHoldoff: begin
                    if (link_up) begin
                        state_d = StIdle;
                    end else if (cnt_q == HoldoffLast) begin
                        state_d      = StSettle;
                        cnt_d        = 32'd0;
                        heater_d     = CodeMin;
                        best_fails_d = NoResult;
                        retry_d      = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StSettle: begin
                    if (cnt_q == SettleLast) begin
                        state_d  = StObserve;
                        cnt_d    = 32'd0;
                        frames_d = 16'd0;
                        fails_d  = 16'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StObserve: begin
                    if (valid) begin
                        frames_d = frames_inc;
                        fails_d  = fails_inc;
                        if (frames_inc == ObsFrames) begin
                            // Strict compare: on a tie the earlier (lower) code stays best.
                            if (fails_inc < best_fails_q) begin
                                best_code_d  = heater_q;
                                best_fails_d = fails_inc;
                            end
                            if (fails_inc == 16'd0 || sweep_end) begin
                                state_d = StApply;
                            end else begin
                                heater_d = next_code_w[CODE_W-1:0];
                                state_d  = StSettle;
                                cnt_d    = 32'd0;
                            end
                        end
                    end
                end
                StApply: begin
                    heater_d = best_code_q;
                    cnt_d    = 32'd0;
                    state_d  = StVerify;
                end
                StVerify: begin
                    if (link_up) begin
                        state_d = StIdle;
                        retry_d = 2'd0;
                    end else if (cnt_q == VerifyLast) begin
                        cnt_d   = 32'd0;
                        state_d = (retry_q == MaxRetries) ? StFault : StHoldoff;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StFault: begin
                    heater_d = best_code_q;
                    if (fault_clear) begin
                        state_d = StIdle;
                        retry_d = 2'd0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // The monitor clear is asserted for exactly the cycle spent in APPLY.
    assign mon_clear_d = (state_d == StApply);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 32'd0;
            frames_q     <= 16'd0;
            fails_q      <= 16'd0;
            heater_q     <= CodeMin;
            best_code_q  <= CodeMin;
            best_fails_q <= NoResult;
            retry_q      <= 2'd0;
            mon_clear_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frames_q     <= frames_d;
            fails_q      <= fails_d;
            heater_q     <= heater_d;
            best_code_q  <= best_code_d;
            best_fails_q <= best_fails_d;
            retry_q      <= retry_d;
            mon_clear_q  <= mon_clear_d;
        end
    end

    assign heater_code = heater_q;
    assign mon_clear   = mon_clear_q;
    assign state       = state_q;
    assign busy        = (state_q != StIdle) && (state_q != StFault);
    assign fault       = (state_q == StFault);
    assign best_code   = best_code_q;
    assign best_fails  = best_fails_q;
    assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_link_recovery_ctrl.sv
// Directed bench for link_recovery_ctrl: holdoff, sweeps, early exit, gapped frames,
// retry-to-fault and reset during observation.
module tb_link_recovery_ctrl;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StHoldoff = 3'd1;
    localparam logic [2:0] StSettle  = 3'd2;
    localparam logic [2:0] StObserve = 3'd3;
    localparam logic [2:0] StApply   = 3'd4;
    localparam logic [2:0] StVerify  = 3'd5;
    localparam logic [2:0] StFault   = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n, enable, link_up, valid, crc_fail, fault_clear;
    logic [7:0]  heater_code, best_code;
    logic        mon_clear, busy, fault;
    logic [2:0]  state;
    logic [15:0] best_fails;
    logic [1:0]  retry_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    link_recovery_ctrl #(
        .CODE_W(8), .CODE_MIN(0), .CODE_MAX(12), .CODE_STEP(4), .HOLDOFF_CYCLES(4),
        .SETTLE_CYCLES(2), .OBS_FRAMES(4), .VERIFY_CYCLES(20), .MAX_RETRIES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .link_up(link_up), .valid(valid),
        .crc_fail(crc_fail), .fault_clear(fault_clear), .heater_code(heater_code),
        .mon_clear(mon_clear), .state(state), .busy(busy), .fault(fault),
        .best_code(best_code), .best_fails(best_fails), .retry_cnt(retry_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input logic [2:0] s, input int budget, output bit ok);
        ok = (state === s);
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = (state === s);
        end
    endtask

    // Waits for OBSERVE, records the code under test and feeds one 4-frame window.
    task automatic do_window(input int nfails, output logic [7:0] code, output bit ok);
        wait_for(StObserve, 80, ok);
        code = heater_code;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                valid    = 1'b1;
                crc_fail = (i < nfails);
                tick();
            end
        end
        valid    = 1'b0;
        crc_fail = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; link_up = 1'b1; valid = 1'b0;
        crc_fail = 1'b0; fault_clear = 1'b0;
        tick(); tick();
        n_cmp++; if (state !== StIdle) begin n_bad++; $display("FAIL rst_state got=%0d exp=%0d", state, StIdle); end
        n_cmp++; if (heater_code !== 8'd0) begin n_bad++; $display("FAIL rst_heater got=%0d exp=0", heater_code); end
        n_cmp++; if (best_code !== 8'd0) begin n_bad++; $display("FAIL rst_best_code got=%0d exp=0", best_code); end
        n_cmp++; if (best_fails !== 16'hFFFF) begin n_bad++; $display("FAIL rst_best_fails got=%h exp=ffff", best_fails); end
        n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_retry got=%0d exp=0", retry_cnt); end
        n_cmp++; if (mon_clear !== 1'b0) begin n_bad++; $display("FAIL rst_mon_clear got=%b exp=0", mon_clear); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault got=%b exp=0", fault); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_holdoff_glitch();
        enable = 1'b1; link_up = 1'b1;
        tick();
        link_up = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (state !== StHoldoff) begin n_bad++; $display("FAIL glitch_holdoff got=%0d exp=%0d", state, StHoldoff); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy got=%b exp=1", busy); end
        link_up = 1'b1;
        tick();
        n_cmp++; if (state !== StIdle) begin n_bad++; $display("FAIL glitch_idle got=%0d exp=%0d", state, StIdle); end
        n_cmp++; if (heater_code !== 8'd0) begin n_bad++; $display("FAIL glitch_heater got=%0d exp=0", heater_code); end
        n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL glitch_retry got=%0d exp=0", retry_cnt); end
    endtask

    task automatic test_full_sweep();
        logic [7:0] c0, c1, c2, c3;
        bit ok0, ok1, ok2, ok3;
        link_up = 1'b0;
        do_window(3, c0, ok0);
        do_window(1, c1, ok1);
        n_cmp++; if (retry_cnt !== 2'd1) begin n_bad++; $display("FAIL sweep_retry got=%0d exp=1", retry_cnt); end
        do_window(1, c2, ok2);
        do_window(2, c3, ok3);
        n_cmp++; if (!(ok0 && ok1 && ok2 && ok3)) begin n_bad++; $display("FAIL sweep_timeout got=%b%b%b%b exp=1111", ok0, ok1, ok2, ok3); end
        n_cmp++; if ({c0, c1, c2, c3} !== 32'h0004080C) begin n_bad++; $display("FAIL sweep_codes got=%h exp=0004080c", {c0, c1, c2, c3}); end
        n_cmp++; if (state !== StApply) begin n_bad++; $display("FAIL sweep_apply got=%0d exp=%0d", state, StApply); end
        n_cmp++; if (mon_clear !== 1'b1) begin n_bad++; $display("FAIL sweep_mon_clear got=%b exp=1", mon_clear); end
        n_cmp++; if (best_code !== 8'd4) begin n_bad++; $display("FAIL sweep_best_code got=%0d exp=4", best_code); end
        n_cmp++; if (best_fails !== 16'd1) begin n_bad++; $display("FAIL sweep_best_fails got=%0d exp=1", best_fails); end
        tick();
        n_cmp++; if (state !== StVerify) begin n_bad++; $display("FAIL sweep_verify got=%0d exp=%0d", state, StVerify); end
        n_cmp++; if (mon_clear !== 1'b0) begin n_bad++; $display("FAIL sweep_mon_pulse got=%b exp=0", mon_clear); end
        n_cmp++; if (heater_code !== 8'd4) begin n_bad++; $display("FAIL sweep_heater got=%0d exp=4", heater_code); end
        link_up = 1'b1;
        tick();
        n_cmp++; if (state !== StIdle) begin n_bad++; $display("FAIL sweep_idle got=%0d exp=%0d", state, StIdle); end
        n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL sweep_retry_clr got=%0d exp=0", retry_cnt); end
    endtask

    task automatic test_early_exit();
        logic [7:0] c0, c1;
        bit ok0, ok1;
        link_up = 1'b0;
        do_window(2, c0, ok0);
        do_window(0, c1, ok1);
        n_cmp++; if (!(ok0 && ok1)) begin n_bad++; $display("FAIL early_timeout got=%b%b exp=11", ok0, ok1); end
        n_cmp++; if ({c0, c1} !== 16'h0004) begin n_bad++; $display("FAIL early_codes got=%h exp=0004", {c0, c1}); end
        n_cmp++; if (state !== StApply) begin n_bad++; $display("FAIL early_apply got=%0d exp=%0d", state, StApply); end
        n_cmp++; if (heater_code !== 8'd4) begin n_bad++; $display("FAIL early_heater got=%0d exp=4", heater_code); end
        n_cmp++; if (best_code !== 8'd4) begin n_bad++; $display("FAIL early_best_code got=%0d exp=4", best_code); end
        n_cmp++; if (best_fails !== 16'd0) begin n_bad++; $display("FAIL early_best_fails got=%0d exp=0", best_fails); end
        tick();
        n_cmp++; if (heater_code !== 8'd4) begin n_bad++; $display("FAIL early_heater_verify got=%0d exp=4", heater_code); end
        link_up = 1'b1;
        tick();
        n_cmp++; if (state !== StIdle) begin n_bad++; $display("FAIL early_idle got=%0d exp=%0d", state, StIdle); end
    endtask

    task automatic test_gapped_valid();
        bit [9:0] vpat = 10'b1000101001;
        bit [9:0] fpat = 10'b0000001010;
        bit ok;
        link_up = 1'b0;
        wait_for(StObserve, 80, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL gap_timeout got=%0d exp=%0d", state, StObserve); end
        for (int i = 0; i < 10; i++) begin
            valid    = vpat[i];
            crc_fail = fpat[i];
            tick();
            if (i == 8) begin
                n_cmp++; if (state !== StObserve) begin n_bad++; $display("FAIL gap_window_open got=%0d exp=%0d", state, StObserve); end
            end
        end
        valid = 1'b0; crc_fail = 1'b0;
        n_cmp++; if (state !== StSettle) begin n_bad++; $display("FAIL gap_window_done got=%0d exp=%0d", state, StSettle); end
        n_cmp++; if (best_fails !== 16'd1) begin n_bad++; $display("FAIL gap_fails got=%0d exp=1", best_fails); end
        n_cmp++; if (best_code !== 8'd0) begin n_bad++; $display("FAIL gap_best_code got=%0d exp=0", best_code); end
        n_cmp++; if (heater_code !== 8'd4) begin n_bad++; $display("FAIL gap_next_code got=%0d exp=4", heater_code); end
        enable = 1'b0;
        tick();
        n_cmp++; if (state !== StIdle) begin n_bad++; $display("FAIL gap_disable got=%0d exp=%0d", state, StIdle); end
        n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL gap_retry got=%0d exp=0", retry_cnt); end
        n_cmp++; if (heater_code !== 8'd4) begin n_bad++; $display("FAIL gap_heater_kept got=%0d exp=4", heater_code); end
        link_up = 1'b1; enable = 1'b1;
        tick();
    endtask

    task automatic test_retry_fault();
        logic [7:0] c;
        bit ok, all_ok;
        all_ok  = 1'b1;
        link_up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_window(1, c, ok);
            all_ok &= ok;
        end
        n_cmp++; if (retry_cnt !== 2'd1) begin n_bad++; $display("FAIL retry_first got=%0d exp=1", retry_cnt); end
        do_window(2, c, ok); all_ok &= ok;
        do_window(1, c, ok); all_ok &= ok;
        do_window(3, c, ok); all_ok &= ok;
        do_window(3, c, ok); all_ok &= ok;
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL retry_sweep_timeout got=0 exp=1"); end
        n_cmp++; if (retry_cnt !== 2'd2) begin n_bad++; $display("FAIL retry_second got=%0d exp=2", retry_cnt); end
        n_cmp++; if (best_code !== 8'd4) begin n_bad++; $display("FAIL retry_best_code got=%0d exp=4", best_code); end
        wait_for(StFault, 40, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL retry_fault_state got=%0d exp=%0d", state, StFault); end
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL retry_fault got=%b exp=1", fault); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL retry_busy got=%b exp=0", busy); end
        n_cmp++; if (heater_code !== 8'd4) begin n_bad++; $display("FAIL retry_heater got=%0d exp=4", heater_code); end
        enable = 1'b0;
        tick(); tick();
        n_cmp++; if (state !== StFault) begin n_bad++; $display("FAIL retry_enable_ignored got=%0d exp=%0d", state, StFault); end
        fault_clear = 1'b1;
        tick();
        fault_clear = 1'b0;
        n_cmp++; if (state !== StIdle) begin n_bad++; $display("FAIL retry_clear_state got=%0d exp=%0d", state, StIdle); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL retry_clear_fault got=%b exp=0", fault); end
        n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL retry_clear_cnt got=%0d exp=0", retry_cnt); end
        link_up = 1'b1; enable = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_observe();
        logic [7:0] c;
        bit ok, all_ok;
        link_up = 1'b0;
        do_window(1, c, ok); all_ok = ok;
        do_window(1, c, ok); all_ok &= ok;
        wait_for(StObserve, 80, ok); all_ok &= ok;
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL midrst_timeout got=0 exp=1"); end
        n_cmp++; if (heater_code !== 8'd8) begin n_bad++; $display("FAIL midrst_code got=%0d exp=8", heater_code); end
        valid = 1'b1; crc_fail = 1'b1;
        tick(); tick();
        rst_n = 1'b0; link_up = 1'b1; valid = 1'b0; crc_fail = 1'b0;
        tick();
        n_cmp++; if (state !== StIdle) begin n_bad++; $display("FAIL midrst_state got=%0d exp=%0d", state, StIdle); end
        n_cmp++; if (heater_code !== 8'd0) begin n_bad++; $display("FAIL midrst_heater got=%0d exp=0", heater_code); end
        n_cmp++; if (best_fails !== 16'hFFFF) begin n_bad++; $display("FAIL midrst_best_fails got=%h exp=ffff", best_fails); end
        n_cmp++; if (mon_clear !== 1'b0) begin n_bad++; $display("FAIL midrst_mon_clear got=%b exp=0", mon_clear); end
        n_cmp++; if (retry_cnt !== 2'd0) begin n_bad++; $display("FAIL midrst_retry got=%0d exp=0", retry_cnt); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (mon_clear !== 1'b0) begin n_bad++; $display("FAIL midrst_mon_after got=%b exp=0", mon_clear); end
    endtask

    initial begin
        test_reset();
        test_holdoff_glitch();
        test_full_sweep();
        test_early_exit();
        test_gapped_valid();
        test_retry_fault();
        test_reset_mid_observe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
